// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared constants and types for the M-extension multiply/divide unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Holds the MULDIV funct7 tag, the eight funct3 opcodes, the FSM state encoding
// and the destination-tag bundle carried from accept to writeback.
package ex_mdu_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    typedef struct packed {
        logic [4:0] wd;
        logic       wreg;
    } mdu_tag_t;

endpackage

// File: rtl/mdu_div.sv
// mdu_div: radix-2 restoring divider on unsigned magnitudes, plus the shared iteration counter.
// Latency: one quotient bit per step; last is high on the XLEN-th step.
// Backpressure: none; the parent gates load/step (step low holds every register).
// Ports: clk, rst (sync, high), clr (abort), load (capture dvd/dvs, zero counter),
//        step (one iteration), dvd/dvs magnitudes in, quo/rem out, last (final step).
module mdu_div
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic            step,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dvs,
    output logic [XLEN-1:0] quo,
    output logic [XLEN-1:0] rem,
    output logic            last
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0] quo_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] dvs_q;
    logic [CW-1:0]   cnt_q;

    // Shift the next dividend bit into the partial remainder and trial-subtract.
    // When the subtraction succeeds the difference is below the divisor, so the
    // low XLEN bits of a plain XLEN-wide subtract are exact.
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] sub;
    logic            ge;

    always_comb begin
        partial = {rem_q, quo_q[XLEN-1]};
        sub     = partial[XLEN-1:0] - dvs_q;
        ge      = (partial >= {1'b0, dvs_q});
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            quo_q <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (load) begin
            quo_q <= dvd;
            rem_q <= '0;
            dvs_q <= dvs;
            cnt_q <= '0;
        end else if (step) begin
            cnt_q <= cnt_q + 1'b1;
            rem_q <= ge ? sub : partial[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], ge};
        end
    end

    assign quo  = quo_q;
    assign rem  = rem_q;
    assign last = (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: RV M-extension multiply/divide unit (FSM, operand conditioning, multiplier, result mux).
// Latency: divide XLEN+1 (zero divisor / signed overflow 1); multiply XLEN+1, or 1 with MDU_FAST_MUL_EN.
// Backpressure: ready_o high only in IDLE; no output backpressure; rdy low freezes all state.
// Ports: clk, rst (sync, high), rdy (global enable), flush (abort), valid_i/ready_o request
//        handshake, funct3_i/op1_i/op2_i/wd_i/wreg_i request, valid_o/result_o/wd_o/wreg_o result.
// Build option: define MDU_FAST_MUL_EN for a single-cycle multiplier instead of shift-add.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            flush,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);
    mdu_state_t      state_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] mag1_q;
    logic            neg_q;      // quotient / product sign
    logic            neg_r_q;    // remainder sign (follows the dividend)
    logic            byp_zero_q;
    logic            byp_ovf_q;
    mdu_tag_t        tag_q;

    // Operand conditioning: signed operands are reduced to magnitudes, the sign is fixed up at the end.
    logic            sgn1, sgn2, neg1, neg2, is_div_i, div_zero, div_ovf, accept, step;
    logic [XLEN-1:0] mag1, mag2;

    always_comb begin
        sgn1     = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
                   (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
        sgn2     = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
        neg1     = sgn1 & op1_i[XLEN-1];
        neg2     = sgn2 & op2_i[XLEN-1];
        mag1     = neg1 ? -op1_i : op1_i;
        mag2     = neg2 ? -op2_i : op2_i;
        is_div_i = funct3_i[2];
        div_zero = (op2_i == '0);
        div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
                   (op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (op2_i == '1);
    end

    assign ready_o = (state_q == IDLE);
    assign accept  = ready_o & valid_i & rdy;
    assign step    = (state_q == CALC) & rdy;

    logic [XLEN-1:0] div_quo, div_rem;
    logic            div_last;

    // The divider also owns the iteration counter that paces the iterative multiplier.
    mdu_div #(.XLEN(XLEN)) u_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .load (accept),
        .step (step),
        .dvd  (mag1),
        .dvs  (mag2),
        .quo  (div_quo),
        .rem  (div_rem),
        .last (div_last)
    );

    logic [2*XLEN-1:0] mag_prod;

`ifdef MDU_FAST_MUL_EN
    localparam logic FAST_MUL = 1'b1;
    logic [XLEN-1:0] mag2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mag2_q <= '0;
        end else if (accept && !flush) begin
            mag2_q <= mag2;
        end
    end

    assign mag_prod = {{XLEN{1'b0}}, mag1_q} * {{XLEN{1'b0}}, mag2_q};
`else
    localparam logic FAST_MUL = 1'b0;
    // Shift-add: low half starts as the multiplier and is consumed LSB first
    // while product bits shift in from the top.
    logic [XLEN-1:0] p_hi, p_lo;
    logic [XLEN:0]   sum;

    assign sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mag1_q} : '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            p_hi <= '0;
            p_lo <= '0;
        end else if (accept) begin
            p_hi <= '0;
            p_lo <= mag2;
        end else if (step) begin
            p_hi <= sum[XLEN:1];
            p_lo <= {sum[0], p_lo[XLEN-1:1]};
        end
    end

    assign mag_prod = {p_hi, p_lo};
`endif

    // Result mux evaluated in DONE.
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, res;

    always_comb begin
        prod_fix = neg_q   ? -mag_prod : mag_prod;
        quo_fix  = neg_q   ? -div_quo  : div_quo;
        rem_fix  = neg_r_q ? -div_rem  : div_rem;
        res      = '0;
        if (!f3_q[2]) begin
            res = (f3_q == F3_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        end else if (byp_zero_q) begin
            res = f3_q[1] ? op1_q : '1;
        end else if (byp_ovf_q) begin
            res = f3_q[1] ? '0 : op1_q;
        end else begin
            res = f3_q[1] ? rem_fix : quo_fix;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_o    <= 1'b0;
            result_o   <= '0;
            wd_o       <= '0;
            wreg_o     <= 1'b0;
            f3_q       <= '0;
            op1_q      <= '0;
            mag1_q     <= '0;
            neg_q      <= 1'b0;
            neg_r_q    <= 1'b0;
            byp_zero_q <= 1'b0;
            byp_ovf_q  <= 1'b0;
            tag_q      <= '0;
        end else if (flush) begin
            state_q  <= IDLE;
            valid_o  <= 1'b0;
            result_o <= '0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
        end else if (rdy) begin
            valid_o  <= 1'b0;
            result_o <= '0;
            wd_o     <= '0;
            wreg_o   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        f3_q       <= funct3_i;
                        op1_q      <= op1_i;
                        mag1_q     <= mag1;
                        neg_q      <= neg1 ^ neg2;
                        neg_r_q    <= neg1;
                        byp_zero_q <= is_div_i & div_zero;
                        byp_ovf_q  <= is_div_i & div_ovf;
                        tag_q      <= '{wd: wd_i, wreg: wreg_i};
                        if (is_div_i ? (div_zero | div_ovf) : FAST_MUL) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (div_last) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    valid_o  <= 1'b1;
                    result_o <= res;
                    wd_o     <= tag_q.wd;
                    wreg_o   <= tag_q.wreg;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: self-checking bench for ex_mdu (XLEN=32).
// Directed vector table, hand-written abort/stall sequences, then random ops
// checked against an arithmetic reference model.
module tb_ex_mdu;
    localparam int XLEN = 32;

    localparam logic [2:0] T_MUL    = 3'd0;
    localparam logic [2:0] T_MULH   = 3'd1;
    localparam logic [2:0] T_MULHSU = 3'd2;
    localparam logic [2:0] T_MULHU  = 3'd3;
    localparam logic [2:0] T_DIV    = 3'd4;
    localparam logic [2:0] T_DIVU   = 3'd5;
    localparam logic [2:0] T_REM    = 3'd6;
    localparam logic [2:0] T_REMU   = 3'd7;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic            clk;
    logic            rst;
    logic            rdy;
    logic            flush;
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] op1_i;
    logic [XLEN-1:0] op2_i;
    logic [4:0]      wd_i;
    logic            wreg_i;
    logic            valid_o;
    logic [XLEN-1:0] result_o;
    logic [4:0]      wd_o;
    logic            wreg_o;

    ex_mdu #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .flush    (flush),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .funct3_i (funct3_i),
        .op1_i    (op1_i),
        .op2_i    (op2_i),
        .wd_i     (wd_i),
        .wreg_i   (wreg_i),
        .valid_o  (valid_o),
        .result_o (result_o),
        .wd_o     (wd_o),
        .wreg_o   (wreg_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: RISC-V M-extension semantics with wide integer arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        p  = '0;
        case (f3)
            T_MUL:    begin p = sa * sb;                 return p[31:0];  end
            T_MULH:   begin p = sa * sb;                 return p[63:32]; end
            T_MULHSU: begin p = sa * ub;                 return p[63:32]; end
            T_MULHU:  begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            T_DIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            T_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            T_REM:    begin
                if (b == 32'd0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default:  return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < T_DIV) return MUL_LAT;
        if (b == 32'd0) return 1;
        if ((f3 == T_DIV || f3 == T_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Issue one op, measure latency from the accept edge, check result, tags,
    // busy indication and single-cycle strobe. Optional rdy stall and junk
    // requests held on valid_i while the unit is busy.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] wd, input logic wr,
                          input logic [31:0] exp_res, input int exp_lat,
                          input int stall_at, input int stall_len, input bit junk);
        int lat;
        bit busy_ok;
        @(negedge clk);
        chk({nm, ".ready"}, 32'(ready_o), 1);
        funct3_i = f3; op1_i = a; op2_i = b; wd_i = wd; wreg_i = wr; valid_i = 1'b1;
        @(negedge clk);
        if (junk) begin
            funct3_i = T_DIVU; op1_i = $urandom; op2_i = 32'd1; wd_i = 5'h1f; wreg_i = ~wr;
        end else begin
            valid_i = 1'b0;
        end
        lat = 0;
        busy_ok = 1'b1;
        while (lat < 200) begin
            if (valid_o) break;
            if (ready_o) busy_ok = 1'b0;
            if (junk && lat >= exp_lat - 1) valid_i = 1'b0;
            if (lat == stall_at) rdy = 1'b0;
            if (lat == stall_at + stall_len) rdy = 1'b1;
            @(negedge clk);
            lat++;
        end
        valid_i = 1'b0;
        rdy = 1'b1;
        chk({nm, ".valid"},   32'(valid_o), 1);
        chk({nm, ".latency"}, lat, exp_lat);
        chk({nm, ".result"},  result_o, exp_res);
        chk({nm, ".wd"},      32'(wd_o), 32'(wd));
        chk({nm, ".wreg"},    32'(wreg_o), 32'(wr));
        chk({nm, ".busy"},    32'(busy_ok), 1);
        @(negedge clk);
        chk({nm, ".strobe"},  32'(valid_o), 0);
        chk({nm, ".res_idle"}, result_o, 0);
    endtask

    // Start an op, then abort it with flush or rst after n cycles; no result may appear.
    task automatic abort_op(input string nm, input bit use_rst, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] b, input int n);
        int stray;
        @(negedge clk);
        funct3_i = f3; op1_i = a; op2_i = b; wd_i = 5'd9; wreg_i = 1'b1; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (n) @(negedge clk);
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        chk({nm, ".ready"},  32'(ready_o), 1);
        chk({nm, ".valid"},  32'(valid_o), 0);
        chk({nm, ".result"}, result_o, 0);
        chk({nm, ".wd"},     32'(wd_o), 0);
        chk({nm, ".wreg"},   32'(wreg_o), 0);
        stray = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_o) stray++;
        end
        chk({nm, ".stray"}, stray, 0);
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vt[13];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = '{T_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vt[1]  = '{T_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vt[2]  = '{T_DIVU,   32'd100,       32'd0,         32'hFFFF_FFFF, 1};
        vt[3]  = '{T_REMU,   32'd100,       32'd0,         32'h0000_0064, 1};
        vt[4]  = '{T_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
        vt[5]  = '{T_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
        vt[6]  = '{T_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT};
        vt[7]  = '{T_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT};
        vt[8]  = '{T_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT};
        vt[9]  = '{T_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT};
        vt[10] = '{T_DIV,    32'd7,         32'd0,         32'hFFFF_FFFF, 1};
        vt[11] = '{T_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1};
        vt[12] = '{T_DIVU,   32'd7,         32'd3,         32'h0000_0002, 33};

        rst = 1'b1; rdy = 1'b1; flush = 1'b0; valid_i = 1'b0;
        funct3_i = '0; op1_i = '0; op2_i = '0; wd_i = '0; wreg_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.ready",  32'(ready_o), 1);
        chk("reset.valid",  32'(valid_o), 0);
        chk("reset.result", result_o, 0);
        chk("reset.wd",     32'(wd_o), 0);
        chk("reset.wreg",   32'(wreg_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset.ready", 32'(ready_o), 1);

        for (int i = 0; i < 13; i++) begin
            run_op($sformatf("vec%0d", i), vt[i].f3, vt[i].a, vt[i].b, 5'(i + 3), i[0],
                   vt[i].exp, vt[i].lat, -1, 0, 1'b0);
        end

        // Requests presented while busy must be ignored.
        run_op("busy_ignore", T_DIV, 32'hFFFF_FFF9, 32'd2, 5'd21, 1'b1, 32'hFFFF_FFFD, 33, -1, 0, 1'b1);

        // rdy held low while idle blocks acceptance.
        @(negedge clk);
        rdy = 1'b0; funct3_i = T_DIVU; op1_i = 32'd9; op2_i = 32'd0; valid_i = 1'b1;
        repeat (3) @(negedge clk);
        valid_i = 1'b0; rdy = 1'b1;
        chk("rdy_block.ready", 32'(ready_o), 1);
        repeat (3) @(negedge clk);
        chk("rdy_block.valid", 32'(valid_o), 0);

        // Flush at CALC iteration 10, then a clean divide with its own tag.
        abort_op("flush_calc", 1'b0, T_DIV, 32'd1000, 32'd7, 10);
        run_op("after_flush", T_DIVU, 32'd7, 32'd3, 5'd13, 1'b1, 32'h0000_0002, 33, -1, 0, 1'b0);

        // Flush landing on the DONE cycle of a bypass op suppresses the strobe.
        abort_op("flush_done", 1'b0, T_DIVU, 32'd5, 32'd0, 0);

        // rdy low for 5 cycles mid-divide stretches latency to 38.
        run_op("stall", T_DIV, 32'hFFFF_FFF9, 32'd2, 5'd17, 1'b0, 32'hFFFF_FFFD, 38, 10, 5, 1'b0);

        // Reset in the middle of a divide.
        abort_op("rst_mid", 1'b1, T_DIV, 32'd12345, 32'd11, 5);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            int          sel;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 15);
            if (sel == 0) b = 32'd0;
            else if (sel < 4) b = 32'($urandom_range(1, 20));
            else if (sel == 4) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 5) a = 32'($urandom_range(0, 100));
            run_op($sformatf("rnd%0d_f%0d", i, f3), f3, a, b, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), ref_res(f3, a, b), ref_lat(f3, a, b), -1, 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter: XLEN, 32, datapath width; legal values 32 or 64.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 rdy  input  1  global enable; low freezes all state.
REQ-005 flush  input  1  abort in-flight operation (branch mispredict/exception).
REQ-006 valid_i  input  1  request valid.
REQ-007 ready_o  output  1  unit can accept a request.
REQ-008 funct3_i  input  3  RV M-extension op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 op1_i, op2_i  input  XLEN each  rs1 / rs2 operand values.
REQ-010 wd_i  input  5  destination register address.
REQ-011 wreg_i  input  1  write-enable tag.
REQ-012 valid_o  output  1  single-cycle result strobe.
REQ-013 result_o  output  XLEN  result; zero when valid_o low.
REQ-014 wd_o, wreg_o  output  5, 1  tags captured at accept; presented with valid_o.

Function
REQ-015 The FSM SHALL use states IDLE, CALC, DONE; ready_o = (state==IDLE).
REQ-016 Accept SHALL occur on a rising edge with valid_i & ready_o & rdy; operands, funct3 and tags are latched.
REQ-017 Divide ops SHALL go IDLE->CALC, perform one radix-2 restoring iteration per cycle for XLEN cycles, then CALC->DONE.
REQ-018 DONE SHALL assert valid_o for exactly one cycle and return to IDLE; normal divide latency is XLEN+1 cycles from the accept edge to valid_o.
REQ-019 Signed ops SHALL iterate on magnitudes; quotient is negated when operand signs differ; remainder takes the dividend's sign.
REQ-020 Divisor zero SHALL bypass CALC (IDLE->DONE, latency 1): quotient all-ones; remainder equals the dividend.
REQ-021 Signed overflow (op1 = -2^(XLEN-1), op2 = -1, DIV/REM) SHALL bypass CALC with latency 1: quotient = op1; remainder = 0.
REQ-022 Multiply SHALL form a 2*XLEN product: MUL returns the low half; MULH returns the high half signed x signed; MULHSU returns it signed x unsigned; MULHU returns it unsigned x unsigned.
REQ-023 valid_i SHALL be ignored while ready_o is low; there is no output back-pressure.
REQ-024 flush SHALL force IDLE on the next edge, suppress any pending valid_o, and take effect regardless of rdy.
REQ-025 Precedence SHALL be: rst > flush > rdy hold > normal operation.
REQ-026 With rdy low, the state, iteration counter and outputs SHALL hold; latency extends by the number of stalled cycles.

Reset
REQ-027 On rst, the unit SHALL return to IDLE with counter 0, and valid_o, result_o, wd_o and wreg_o at 0.
REQ-028 rst asserted mid-operation SHALL discard that operation; no valid_o is produced for it.
REQ-029 ready_o SHALL be 1 on the first cycle after rst deasserts.

Configuration
REQ-030 With MDU_FAST_MUL_EN defined, multiplies SHALL use a single-cycle multiplier (IDLE->DONE, latency 1).
REQ-031 Without MDU_FAST_MUL_EN, multiplies SHALL use iterative shift-add through CALC (XLEN iterations, latency XLEN+1), with sign fixup in DONE.
REQ-032 Divide behaviour SHALL be identical with and without the macro.

Structure
REQ-033 The shared package SHALL hold the MULDIV_FUNCT7 constant (0000001), the eight M-extension funct3 constants, and the FSM state encoding.
REQ-034 The divider datapath (magnitude registers, iteration counter, restore step) SHALL be a sub-module named mdu_div; ex_mdu contains the FSM, operand conditioning, multiplier and result mux.

Verification (XLEN=32)
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> result 0x80000000 with valid_o 1 cycle after accept; REM of the same operands -> 0x00000000.
REQ-036 DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 0x00000064; each with latency 1.
REQ-037 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; valid_o exactly 33 cycles after accept; ready_o low throughout.
REQ-038 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL of the same operands -> 0x00000001; run both with and without MDU_FAST_MUL_EN, checking latency 1 / 33.
REQ-039 flush at CALC iteration 10 -> no valid_o, ready_o high on the next cycle; a following DIVU 7 / 3 -> 0x00000002 with correct wd_o.
REQ-040 rdy low for 5 cycles mid-divide -> valid_o at 38 cycles with an unchanged result; rst mid-operation -> all outputs 0 and no stray valid_o.
